// File: rtl/dct_pkg.sv
// Shared types, constants and helpers for the ping-pong DCT/FFT frame scheduler.
package dct_pkg;

  // Per-lane buffer state
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFill  = 2'd1,
    StFull  = 2'd2,
    StDrain = 2'd3
  } lane_state_e;

  localparam int unsigned FftptsMin = 8;
  localparam int unsigned FftptsMax = 2048;

  // Legal frame length: a power of two within [FftptsMin, FftptsMax]
  function automatic logic fftpts_legal(input logic [31:0] pts);
    return (pts >= FftptsMin) && (pts <= FftptsMax) && ((pts & (pts - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/dct_pp_lane.sv
// One ping-pong lane: tracks EMPTY/FILL/FULL/DRAIN and counts beats of the frame being filled.
module dct_pp_lane
  import dct_pkg::*;
#(
  parameter int unsigned FFTPTS_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_beat,        // accepted beat steered to this lane
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic [FFTPTS_W-1:0] i_fftpts,
  input  logic                i_rd_grant,    // this lane is the one granted to the FFT
  input  logic                i_fft_ready,
  input  logic                i_drain_eop,
  output lane_state_e         o_state_next,
  output logic                o_fill_done,
  output logic                o_err,
  output logic                o_start,
  output logic                o_drain_done
);

  lane_state_e         r_state, w_state_d;
  logic [FFTPTS_W-1:0] r_len, w_len_d;
  logic [FFTPTS_W-1:0] r_cnt, w_cnt_d;
  logic                r_drop, w_drop_d;
  logic [FFTPTS_W-1:0] w_cnt_inc;
  logic                w_legal;

  assign w_cnt_inc    = r_cnt + FFTPTS_W'(1);
  assign w_legal      = fftpts_legal(32'(i_fftpts));
  assign o_state_next = w_state_d;

  // Next-state for the lane: fill-side events in EMPTY/FILL, drain-side events in FULL/DRAIN
  always_comb begin
    w_state_d    = r_state;
    w_len_d      = r_len;
    w_cnt_d      = r_cnt;
    w_drop_d     = r_drop;
    o_fill_done  = 1'b0;
    o_err        = 1'b0;
    o_start      = 1'b0;
    o_drain_done = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (i_beat) begin
          if (i_sop) begin
            w_drop_d = 1'b0;
            if (!w_legal) begin
              // Bad length: discard the rest of this frame silently
              o_err    = 1'b1;
              w_drop_d = 1'b1;
            end else if (i_eop) begin
              // sop+eop is a one-beat frame, never a legal length
              o_err = 1'b1;
            end else begin
              w_state_d = StFill;
              w_len_d   = i_fftpts;
              w_cnt_d   = FFTPTS_W'(1);
            end
          end else if (!r_drop) begin
            o_err = 1'b1;
          end
        end
      end
      StFill: begin
        if (i_beat) begin
          if (i_sop) begin
            // Early sop aborts the current frame and restarts on the new one
            o_err = 1'b1;
            if (!w_legal) begin
              w_state_d = StEmpty;
              w_drop_d  = 1'b1;
            end else if (i_eop) begin
              w_state_d = StEmpty;
            end else begin
              w_len_d = i_fftpts;
              w_cnt_d = FFTPTS_W'(1);
            end
          end else if (i_eop) begin
            if (w_cnt_inc == r_len) begin
              w_state_d   = StFull;
              o_fill_done = 1'b1;
            end else begin
              o_err     = 1'b1;
              w_state_d = StEmpty;
            end
          end else if (w_cnt_inc == r_len) begin
            // Length reached with no eop: drop the overrun tail until the next sop
            o_err     = 1'b1;
            w_state_d = StEmpty;
            w_drop_d  = 1'b1;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
      end
      StFull: begin
        if (i_rd_grant && i_fft_ready) begin
          w_state_d = StDrain;
          o_start   = 1'b1;
        end
      end
      StDrain: begin
        if (i_rd_grant && i_drain_eop) begin
          w_state_d    = StEmpty;
          o_drain_done = 1'b1;
        end
      end
    endcase
  end

  // Lane state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StEmpty;
      r_len   <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_cnt   <= w_cnt_d;
      r_drop  <= w_drop_d;
    end
  end

endmodule

// File: rtl/dct_pp_sched.sv
// Ping-pong frame scheduler: fills one lane from the sink while the other drains into a shared FFT.
module dct_pp_sched
  import dct_pkg::*;
#(
  parameter int unsigned FFTPTS_W = 12,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sink_valid,
  input  logic                sink_sop,
  input  logic                sink_eop,
  output logic                sink_ready,
  input  logic [FFTPTS_W-1:0] fftpts_in,
  output logic                wr_sel,
  input  logic                fft_ready,
  input  logic                drain_eop,
  output logic                rd_sel,
  output logic                rd_start,
  output logic                rd_en,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frames_done,
  output logic [CNT_W-1:0]    err_cnt
);

  lane_state_e w_state_next [2];
  logic [1:0]  w_beat;
  logic [1:0]  w_grant;
  logic [1:0]  w_fill_done;
  logic [1:0]  w_err;
  logic [1:0]  w_start;
  logic [1:0]  w_drain_done;
  logic        w_accept;
  logic        w_wr_sel_d;
  logic        w_rd_sel_d;
  logic        w_sink_ready_d;
  logic        w_rd_en_d;

  logic             r_sink_ready;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic             r_rd_start;
  logic             r_rd_en;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frames_done;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_accept  = sink_valid & r_sink_ready;
  assign w_beat[0] = w_accept & ~r_wr_sel;
  assign w_beat[1] = w_accept & r_wr_sel;
  assign w_grant   = {r_rd_sel, ~r_rd_sel};

  dct_pp_lane #(
    .FFTPTS_W (FFTPTS_W)
  ) u_lane_ping (
    .clk          (clk),
    .rst          (rst),
    .i_beat       (w_beat[0]),
    .i_sop        (sink_sop),
    .i_eop        (sink_eop),
    .i_fftpts     (fftpts_in),
    .i_rd_grant   (w_grant[0]),
    .i_fft_ready  (fft_ready),
    .i_drain_eop  (drain_eop),
    .o_state_next (w_state_next[0]),
    .o_fill_done  (w_fill_done[0]),
    .o_err        (w_err[0]),
    .o_start      (w_start[0]),
    .o_drain_done (w_drain_done[0])
  );

  dct_pp_lane #(
    .FFTPTS_W (FFTPTS_W)
  ) u_lane_pong (
    .clk          (clk),
    .rst          (rst),
    .i_beat       (w_beat[1]),
    .i_sop        (sink_sop),
    .i_eop        (sink_eop),
    .i_fftpts     (fftpts_in),
    .i_rd_grant   (w_grant[1]),
    .i_fft_ready  (fft_ready),
    .i_drain_eop  (drain_eop),
    .o_state_next (w_state_next[1]),
    .o_fill_done  (w_fill_done[1]),
    .o_err        (w_err[1]),
    .o_start      (w_start[1]),
    .o_drain_done (w_drain_done[1])
  );

  // Pointer updates, and ready/rd_en derived from the lanes' next state so the registered
  // flags line up with the lane state and no beat is accepted into a FULL lane
  always_comb begin
    w_wr_sel_d     = r_wr_sel ^ (|w_fill_done);
    w_rd_sel_d     = r_rd_sel ^ (|w_drain_done);
    w_sink_ready_d = (w_state_next[w_wr_sel_d] == StEmpty) ||
                     (w_state_next[w_wr_sel_d] == StFill);
    w_rd_en_d      = (w_state_next[w_rd_sel_d] == StDrain);
  end

  // Registered control outputs and lane pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sink_ready <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_rd_start   <= 1'b0;
      r_rd_en      <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sink_ready <= w_sink_ready_d;
      r_wr_sel     <= w_wr_sel_d;
      r_rd_sel     <= w_rd_sel_d;
      r_rd_start   <= |w_start;
      r_rd_en      <= w_rd_en_d;
      r_frame_err  <= |w_err;
    end
  end

  // Completed-drain counter (wraps) and error counter (saturates)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frames_done <= '0;
      r_err_cnt     <= '0;
    end else begin
      if (|w_drain_done) begin
        r_frames_done <= r_frames_done + CNT_W'(1);
      end
      if ((|w_err) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign sink_ready  = r_sink_ready;
  assign wr_sel      = r_wr_sel;
  assign rd_sel      = r_rd_sel;
  assign rd_start    = r_rd_start;
  assign rd_en       = r_rd_en;
  assign frame_err   = r_frame_err;
  assign frames_done = r_frames_done;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_dct_pp_sched.sv
// Scoreboard bench for dct_pp_sched: frame-level model predicts errors and drains.
module tb_dct_pp_sched;

  localparam int unsigned FW = 12;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sink_valid = 1'b0;
  logic          sink_sop = 1'b0;
  logic          sink_eop = 1'b0;
  logic          sink_ready;
  logic [FW-1:0] fftpts_in = '0;
  logic          wr_sel;
  logic          fft_ready = 1'b0;
  logic          drain_eop = 1'b0;
  logic          rd_sel;
  logic          rd_start;
  logic          rd_en;
  logic          frame_err;
  logic [CW-1:0] frames_done;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  dct_pp_sched #(
    .FFTPTS_W (FW),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_ready  (sink_ready),
    .fftpts_in   (fftpts_in),
    .wr_sel      (wr_sel),
    .fft_ready   (fft_ready),
    .drain_eop   (drain_eop),
    .rd_sel      (rd_sel),
    .rd_start    (rd_start),
    .rd_en       (rd_en),
    .frame_err   (frame_err),
    .frames_done (frames_done),
    .err_cnt     (err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard queues: expected err_cnt at each frame_err pulse, drain sequence numbers
  int exp_err_q[$];
  int drain_q[$];
  int exp_err_cnt = 0;
  int good_done = 0;
  int drains_done = 0;
  int starts_seen = 0;
  bit dropping = 1'b0;
  bit auto_drain = 1'b1;
  bit chk_ready = 1'b0;
  bit rand_fft = 1'b0;
  bit bg_done = 1'b0;
  int mon_v;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fatal_stop(input string name);
    failures++;
    checks++;
    $display("FAIL %s: bound expired", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  endtask

  task automatic exp_err();
    exp_err_cnt = (exp_err_cnt >= 65535) ? 65535 : exp_err_cnt + 1;
    exp_err_q.push_back(exp_err_cnt);
  endtask

  // Monitor: pops expectations whenever the DUT presents frame_err or rd_start
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) begin
        if (exp_err_q.size() == 0) begin
          check("unexpected_frame_err", 1, 0);
        end else begin
          mon_v = exp_err_q.pop_front();
          check("err_cnt_at_pulse", longint'(err_cnt), longint'(mon_v));
        end
      end
      if (rd_start) begin
        if (drain_q.size() == 0) begin
          check("unexpected_rd_start", 1, 0);
        end else begin
          mon_v = drain_q.pop_front();
          check("rd_sel_at_start", longint'(rd_sel), longint'(mon_v % 2));
          check("frames_done_at_start", longint'(frames_done), longint'(mon_v));
          starts_seen++;
        end
      end
      if (chk_ready) begin
        check("sink_ready", longint'(sink_ready), longint'((good_done - drains_done) < 2));
      end
    end
  end

  // FFT emulator: after each rd_start, finish the drain a few cycles later
  initial forever begin
    @(negedge clk);
    if (rd_start && auto_drain && !rst) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk);
        #1;
      end
      drain_eop = 1'b1;
      check("rd_en_during_drain", longint'(rd_en), 1);
      @(posedge clk);
      #1;
      drain_eop = 1'b0;
      drains_done++;
      check("frames_done_after_drain", longint'(frames_done), longint'(drains_done));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_fft) fft_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    fatal_stop("global_watchdog");
  end

  // Drive one beat and hold it until accepted; returns at posedge+1 of acceptance
  task automatic send_beat(input logic s, input logic e, input logic [FW-1:0] p);
    int n;
    n = 0;
    sink_valid = 1'b1;
    sink_sop   = s;
    sink_eop   = e;
    fftpts_in  = p;
    @(negedge clk);
    while (!sink_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!sink_ready) fatal_stop("beat_accept_timeout");
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic good_frame(input int len, input bit restart);
    for (int i = 1; i <= len; i++) begin
      send_beat(i == 1, i == len, FW'(len));
      if (i == 1 && restart) exp_err();
      if (i == len) begin
        drain_q.push_back(good_done);
        good_done++;
      end
      gap();
    end
    dropping = 1'b0;
  endtask

  task automatic short_frame(input int len);
    for (int i = 1; i <= len - 2; i++) begin
      send_beat(i == 1, i == len - 2, FW'(len));
      if (i == len - 2) exp_err();
      gap();
    end
    dropping = 1'b0;
  endtask

  task automatic long_frame(input int len);
    for (int i = 1; i <= len + 2; i++) begin
      send_beat(i == 1, i == len + 2, FW'(len));
      if (i == len) exp_err();
      gap();
    end
    dropping = 1'b1;
  endtask

  task automatic illegal_frame(input logic [FW-1:0] pts, input int nbeats);
    for (int i = 1; i <= nbeats; i++) begin
      send_beat(i == 1, i == nbeats, pts);
      if (i == 1) exp_err();
      gap();
    end
    dropping = 1'b1;
  endtask

  task automatic wait_starts(input int k);
    int n;
    n = 0;
    while (starts_seen < k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (starts_seen < k) fatal_stop("rd_start_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic manual_drain();
    drain_eop = 1'b1;
    @(posedge clk);
    #1;
    drain_eop = 1'b0;
    drains_done++;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((drains_done != good_done || exp_err_q.size() != 0 || drain_q.size() != 0) &&
           n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fatal_stop("settle_timeout");
    repeat (2) @(negedge clk);
    check("settle_frames_done", longint'(frames_done), longint'(good_done));
    check("settle_err_cnt", longint'(err_cnt), longint'(exp_err_cnt));
    check("settle_wr_sel", longint'(wr_sel), longint'(good_done % 2));
    check("settle_rd_sel", longint'(rd_sel), longint'(drains_done % 2));
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] bad_pts [6];
  int            kind;
  int            s0;
  int            n;

  initial begin
    bad_pts = '{12'd0, 12'd4, 12'd12, 12'd100, 12'd24, 12'd4095};

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sink_ready", longint'(sink_ready), 0);
    check("rst_wr_sel", longint'(wr_sel), 0);
    check("rst_rd_sel", longint'(rd_sel), 0);
    check("rst_rd_start", longint'(rd_start), 0);
    check("rst_rd_en", longint'(rd_en), 0);
    check("rst_frame_err", longint'(frame_err), 0);
    check("rst_frames_done", longint'(frames_done), 0);
    check("rst_err_cnt", longint'(err_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_clk", longint'(sink_ready), 0);
    @(posedge clk);
    #1;
    check("ready_after_first_clk", longint'(sink_ready), 1);
    chk_ready = 1'b1;

    // Two back-to-back 64-point frames
    fft_ready = 1'b1;
    good_frame(64, 0);
    good_frame(64, 0);
    settle();
    check("two_frames_done", longint'(frames_done), 2);
    check("two_frames_no_err", longint'(err_cnt), 0);

    // Randomized mix of good and faulty frames
    rand_fft = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: good_frame(8 << $urandom_range(0, 2), 0);
        4: short_frame(8 << $urandom_range(0, 2));
        5: long_frame(8 << $urandom_range(0, 1));
        6: illegal_frame(bad_pts[$urandom_range(0, 5)], $urandom_range(1, 6));
        7: begin
          send_beat(1'b0, 1'($urandom_range(0, 1)), FW'(16));
          if (!dropping) exp_err();
        end
        8: begin
          send_beat(1'b1, 1'b1, FW'(16));
          exp_err();
          dropping = 1'b0;
        end
        default: begin
          for (int i = 1; i <= 3; i++) send_beat(i == 1, 1'b0, FW'(16));
          good_frame(8 << $urandom_range(0, 2), 1);
        end
      endcase
    end
    settle();

    // Eop at beat 30 of a 32-point frame
    s0 = exp_err_cnt;
    short_frame(32);
    settle();
    check("short32_err_delta", longint'(err_cnt), longint'(s0 + 1));

    // Illegal length 100: one error, the 100 beats vanish
    s0 = good_done;
    illegal_frame(FW'(100), 100);
    settle();
    check("illegal100_no_frame", longint'(good_done), longint'(s0));

    // FFT stalled: third frame must wait for a free lane
    rand_fft = 1'b0;
    @(posedge clk);
    #1;
    fft_ready = 1'b0;
    s0 = good_done;
    bg_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) good_frame(16, 0);
        bg_done = 1'b1;
      end
    join_none
    repeat (300) @(posedge clk);
    #1;
    check("stall_two_filled", longint'(good_done), longint'(s0 + 2));
    check("stall_ready_low", longint'(sink_ready), 0);
    fft_ready = 1'b1;
    n = 0;
    while (!bg_done && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (!bg_done) fatal_stop("stall_release_timeout");
    #1;
    settle();
    check("stall_all_drained", longint'(drains_done), longint'(s0 + 3));

    // Fill completion on ping coincides with drain completion on pong
    if (good_done % 2 != 0) begin
      good_frame(8, 0);
      settle();
    end
    auto_drain = 1'b0;
    s0 = starts_seen;
    good_frame(8, 0);
    wait_starts(s0 + 1);
    manual_drain();
    good_frame(8, 0);
    wait_starts(s0 + 2);
    for (int i = 1; i <= 7; i++) send_beat(i == 1, 1'b0, FW'(8));
    drain_eop = 1'b1;
    send_beat(1'b0, 1'b1, FW'(8));
    drain_eop = 1'b0;
    drains_done++;
    drain_q.push_back(good_done);
    good_done++;
    @(negedge clk);
    check("coincide_rd_sel", longint'(rd_sel), 0);
    check("coincide_wr_sel", longint'(wr_sel), 1);
    check("coincide_frames_done", longint'(frames_done), longint'(drains_done));
    wait_starts(s0 + 3);
    manual_drain();
    auto_drain = 1'b1;
    settle();

    // Reset in the middle of a drain
    auto_drain = 1'b0;
    s0 = starts_seen;
    good_frame(8, 0);
    wait_starts(s0 + 1);
    chk_ready = 1'b0;
    rst = 1'b1;
    #2;
    check("mid_rst_sink_ready", longint'(sink_ready), 0);
    check("mid_rst_rd_en", longint'(rd_en), 0);
    check("mid_rst_rd_start", longint'(rd_start), 0);
    check("mid_rst_frame_err", longint'(frame_err), 0);
    check("mid_rst_frames_done", longint'(frames_done), 0);
    check("mid_rst_err_cnt", longint'(err_cnt), 0);
    check("mid_rst_wr_sel", longint'(wr_sel), 0);
    check("mid_rst_rd_sel", longint'(rd_sel), 0);
    exp_err_q.delete();
    drain_q.delete();
    good_done   = 0;
    drains_done = 0;
    exp_err_cnt = 0;
    dropping    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_ready  = 1'b1;
    auto_drain = 1'b1;
    good_frame(8, 0);
    settle();
    check("post_rst_frames_done", longint'(frames_done), 1);
    check("post_rst_err_cnt", longint'(err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
